// File: rtl/t_using_d_pkg.sv
// Shared constants for the T-flop-from-D-flop counter.
package t_using_d_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/t_using_d.sv
// Single T flip-flop built from a D flop with XOR feedback.
// Reset is asynchronous, active-low, and loads INIT_BIT.
module t_using_d
  import t_using_d_pkg::*;
#(
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic q_bar
);

  logic q_d;
  logic q_q;

  // Toggle when t is set, otherwise hold.
  always_comb begin
    q_d = q_q ^ t;
  end

  // D flop holding the bit.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      q_q <= INIT_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/t_using_d_counter.sv
// Up/down counter where every bit is a T flop built from a D flop.
// Load has priority over count enable; tc flags the terminal count and
// wrap pulses one cycle after a wrap-around.
// Optional macro T_USING_D_COUNTER_SAT_EN: saturate at the terminal
// count instead of wrapping (wrap then stays 0).
module t_using_d_counter
  import t_using_d_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned INIT  = 0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] t,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH-1:0] t_d;
  logic             tc_d;
  logic             chain;

  // Toggle vector: load difference, ripple chain for counting, or zero.
  always_comb begin
    t_d   = '0;
    tc_d  = 1'b0;
    chain = 1'b1;
    if (rst) begin
      if (load) begin
        t_d = q ^ load_val;
      end else if (en) begin
        tc_d = (up == DIR_UP) ? (q == '1) : (q == '0);
        for (int unsigned i = 0; i < WIDTH; i++) begin
          t_d[i] = chain;
          chain  = chain & ((up == DIR_UP) ? q[i] : q_bar[i]);
        end
`ifdef T_USING_D_COUNTER_SAT_EN
        if (tc_d) begin
          t_d = '0;
        end
`endif
      end
    end
  end

  assign t  = t_d;
  assign tc = tc_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_using_d #(
      .INIT_BIT (INIT_V[i])
    ) u_t_using_d (
      .clock (clock),
      .rst   (rst),
      .t     (t_d[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

`ifdef T_USING_D_COUNTER_SAT_EN
  assign wrap = 1'b0;
`else
  logic wrap_d;
  logic wrap_q;

  // Without saturation every terminal-count edge wraps.
  always_comb begin
    wrap_d = tc_d;
  end

  // One-cycle wrap pulse register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_t_using_d_counter.sv
// Scoreboard bench for t_using_d_counter (WIDTH=4, INIT=0).
module tb_t_using_d_counter;

  localparam int unsigned W    = 4;
  localparam logic [W-1:0] INI = 4'd0;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic [W-1:0] t;
  logic         tc;
  logic         wrap;

  t_using_d_counter #(
    .WIDTH (W),
    .INIT  (0)
  ) dut (
    .clock    (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .q_bar    (q_bar),
    .t        (t),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] t;
    logic         tc;
    logic         wrap;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: value and wrap flag as seen right now.
  logic [W-1:0] m_q    = INI;
  logic         m_wrap = 1'b0;

  task automatic chk(input string name, input int c, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle to the oldest entry.
  initial begin
    exp_t         e;
    logic [W-1:0] nq;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        nq = ~e.q;
        chk("q",     e.cyc, q,     e.q);
        chk("q_bar", e.cyc, q_bar, nq);
        chk("t",     e.cyc, t,     e.t);
        chk("tc",    e.cyc, {3'b0, tc},   {3'b0, e.tc});
        chk("wrap",  e.cyc, {3'b0, wrap}, {3'b0, e.wrap});
      end
    end
  end

  // Apply one cycle of inputs just after a rising edge, record expectation,
  // then step the model to the value the next edge must produce.
  task automatic drive(input logic r, input logic e_i, input logic u_i,
                       input logic l_i, input logic [W-1:0] lv);
    exp_t         e;
    logic [W-1:0] nxt;
    logic         term;
    logic         nwrap;
    @(posedge clk);
    #1;
    rst = r; en = e_i; up = u_i; load = l_i; load_val = lv;
    if (!r) begin
      m_q    = INI;
      m_wrap = 1'b0;
    end
    term  = r && e_i && !l_i && (u_i ? (m_q == 4'd15) : (m_q == 4'd0));
    nwrap = 1'b0;
    if (!r)        nxt = INI;
    else if (l_i)  nxt = lv;
    else if (!e_i) nxt = m_q;
    else begin
`ifdef T_USING_D_COUNTER_SAT_EN
      nxt = term ? m_q : (u_i ? m_q + 4'd1 : m_q - 4'd1);
`else
      nxt   = u_i ? m_q + 4'd1 : m_q - 4'd1;
      nwrap = term;
`endif
    end
    e.q    = m_q;
    e.t    = m_q ^ nxt;
    e.tc   = term;
    e.wrap = m_wrap;
    e.cyc  = cyc;
    sb.push_back(e);
    m_q    = nxt;
    m_wrap = nwrap;
    cyc++;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

    // Reset, then release and hold.
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 5);
    drive(1, 0, 1, 0, 0);

    // Full up-count cycle through wrap.
    repeat (16) drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);

    // Down from zero.
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Asynchronous reset between edges while q=9, then resume counting.
    drive(1, 0, 1, 1, 9);
    drive(1, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    repeat (3) drive(1, 1, 1, 0, 0);

    // Load coincident with terminal count.
    drive(1, 0, 1, 1, 15);
    drive(1, 1, 1, 1, 6);
    drive(1, 0, 1, 0, 0);

    // Direction change each edge from 7.
    drive(1, 0, 1, 1, 7);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom),
            ($urandom_range(0, 7) == 0),
            W'($urandom));
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
